// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one free-running 10-bit PRNG among N_REQ requesters.
// Sequences PRNG reseed/warm-up and returns one unbiased value in 0..Max per grant.
module rng_arbiter #(
  parameter int         N_REQ     = 4,
  parameter int         MAX_TRIES = 8,
  parameter int         WARMUP    = 3,
  parameter logic [9:0] SEED_INIT = 10'h2A5
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [N_REQ-1:0]   Req,
  input  logic [10*N_REQ-1:0] Max,
  output logic [N_REQ-1:0]   Ack,
  output logic [9:0]         Value,
  input  logic               Reseed,
  input  logic [9:0]         Seed,
  output logic               Busy,
  output logic               Prng_Reset,
  output logic [9:0]         Prng_Seed,
  input  logic [9:0]         Prng_Out,
  output logic [1:0]         Dbg_State
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {HOLD = 2'd0, WARM = 2'd1, IDLE = 2'd2, DRAW = 2'd3} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   ptr, id, gnt_id;
  logic [9:0]        max_l, mask, gnt_max, gnt_mask;
  logic [9:0]        draw_m, pend_seed, new_seed;
  logic [3:0]        tries, cnt;
  logic              pend, gnt_found, draw_ok, draw_last, reseed_go;
  logic [N_REQ-1:0]  eligible;
  int                idx;

  // A requester whose Ack is high this cycle is excluded, so a lingering Req is not re-granted.
  assign eligible  = Req & ~Ack;
  assign reseed_go = Reseed | pend;
  assign new_seed  = Reseed ? Seed : pend_seed;
  assign draw_m    = Prng_Out & mask;
  assign draw_ok   = (draw_m <= max_l);
  assign draw_last = (tries == 4'(MAX_TRIES - 1));
  assign Busy      = (state != IDLE) | pend;
  assign Dbg_State = state;

  // Round-robin search from ptr+1; iterating downward lets the nearest candidate win.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (eligible[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  // Smallest 2^k-1 covering the bound: smear the top set bit downward.
  always_comb begin
    gnt_max  = Max[int'(gnt_id)*10 +: 10];
    gnt_mask = gnt_max | (gnt_max >> 1);
    gnt_mask = gnt_mask | (gnt_mask >> 2);
    gnt_mask = gnt_mask | (gnt_mask >> 4);
    gnt_mask = gnt_mask | (gnt_mask >> 8);
  end

  always_comb begin
    state_nx = state;
    case (state)
      HOLD: state_nx = WARM;
      WARM: if (cnt == 4'd0) state_nx = IDLE;
      IDLE: begin
        if (reseed_go)      state_nx = HOLD;
        else if (gnt_found) state_nx = DRAW;
      end
      DRAW: if (draw_ok || draw_last) state_nx = IDLE;
      default: state_nx = HOLD;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= HOLD;
      Prng_Reset <= 1'b1;
      Prng_Seed  <= SEED_INIT;
      Ack        <= '0;
      Value      <= '0;
      pend       <= 1'b0;
      pend_seed  <= '0;
      tries      <= '0;
      cnt        <= '0;
      ptr        <= ID_W'(N_REQ - 1);
      id         <= '0;
      max_l      <= '0;
      mask       <= '0;
    end else begin
      state      <= state_nx;
      Prng_Reset <= (state_nx == HOLD);
      Ack        <= '0;
      case (state)
        HOLD: cnt <= 4'(WARMUP - 1);
        WARM: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        IDLE: begin
          if (reseed_go) begin
            Prng_Seed <= (new_seed == 10'd0) ? SEED_INIT : new_seed;
            pend      <= 1'b0;
          end else if (gnt_found) begin
            id    <= gnt_id;
            max_l <= gnt_max;
            mask  <= gnt_mask;
            tries <= '0;
          end
        end
        DRAW: begin
          if (draw_ok || draw_last) begin
            // Fallback folds the overshoot back; mask < 2*(max+1) keeps it within range.
            Value <= draw_ok ? draw_m : (draw_m - max_l - 10'd1);
            Ack   <= {{(N_REQ-1){1'b0}}, 1'b1} << id;
            ptr   <= id;
          end else begin
            tries <= tries + 4'd1;
          end
        end
        default: ;
      endcase
      if (state != IDLE && Reseed) begin
        pend      <= 1'b1;
        pend_seed <= Seed;
      end
    end
  end

endmodule

// File: doc/rng_arbiter.md
# rng_arbiter

Shares the single free-running 10-bit PRNG among several requesters in the game logic (spawners, AI, effects). Owns the PRNG's reset/seed inputs, sequences reseeding and warm-up, round-robin arbitrates requests, and returns one bounded random value per grant in the range 0..Max. Rejection sampling keeps values unbiased, with a guaranteed-termination fallback.

## Interface
- N_REQ, 4: number of requesters (2..8).
- MAX_TRIES, 8: draws per grant before the fallback applies (1..15).
- WARMUP, 3: PRNG clocks discarded after every PRNG reset (1..15).
- SEED_INIT, 10'h2A5: seed applied at reset; also replaces any all-zero seed.

Ports:
- Clk  in  1  system clock, all logic on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  N_REQ  per-requester level request.
- Max  in  10*N_REQ  requester i bound in bits [10i+9:10i]; must be stable while Req[i] is high.
- Ack  out  N_REQ  one-hot, one-cycle pulse; Value is valid while it is high.
- Value  out  10  result, always ≤ the latched Max; holds until the next Ack.
- Reseed  in  1  single-cycle reseed request.
- Seed  in  10  sampled when Reseed is high.
- Busy  out  1  high in any state other than IDLE, or while a reseed is pending.
- Prng_Reset  out  1  to the PRNG's active-high Reset; registered.
- Prng_Seed  out  10  to the PRNG's Seed; stable whenever Prng_Reset is high.
- Prng_Out  in  10  PRNG output; a new value every clock.

## Operation
- States: HOLD, WARM, IDLE, DRAW.
- HOLD:
  - Prng_Reset = 1 for exactly one cycle.
  - Next state is WARM; the warm-up counter loads WARMUP-1.
- WARM: the counter decrements every cycle. At 0, go to IDLE.
- IDLE, reseed:
  - Service a reseed if Reseed is high this edge or one is pending.
  - Prng_Seed ← the captured Seed, or SEED_INIT if that Seed is 0.
  - Clear the pending flag and go to HOLD.
  - Reseed has priority over Req on the same edge.
- IDLE, grant (no reseed):
  - Eligible requesters are those with Req[i] high, excluding any i whose Ack[i] is high this cycle.
  - Grant the first eligible requester searching upward from ptr+1 with wrap-around (round-robin).
  - Latch id and Max[id]. Compute mask = smallest 2^k−1 ≥ Max (Max=0 gives mask=0). Clear tries. Go to DRAW.
- DRAW, each edge, with m = Prng_Out & mask:
  - If m ≤ Max: Value ← m.
  - Else if tries == MAX_TRIES−1: Value ← m − (Max+1). This is always ≤ Max because mask < 2(Max+1).
  - Else: tries++ and stay in DRAW.
  - On the first two outcomes: pulse Ack[id], set ptr ← id, go to IDLE.
- A Reseed arriving in any state other than IDLE sets the pending flag and captures Seed. The last capture wins.
- Reset_n low, asynchronously:
  - State = HOLD, Prng_Reset = 1, Prng_Seed = SEED_INIT.
  - Ack = 0, Value = 0, Busy = 1.
  - Pending flag, tries and counter cleared; ptr = N_REQ−1, so requester 0 wins first.
  - A grant in progress is abandoned; no Ack is issued for it.

## Timing
- After Reset_n rises: HOLD for 1 cycle, then WARM for WARMUP cycles; IDLE is first reached 1+WARMUP edges later.
- Grant latency:
  - Req is seen in IDLE at edge k.
  - The first draw happens at edge k+1. Ack is high in the cycle after edge k+1+r, where r is the number of rejections (0..MAX_TRIES−1).
  - Minimum is 2 edges from Req being sampled to Ack being visible.
- Throughput: at most one grant every 2 cycles. No two Acks are ever high in the same cycle.
- Requester handshake:
  - The requester must drop Req in the cycle after Ack.
  - Req still high at the edge after Ack's cycle counts as a new request.
- Each draw consumes a distinct PRNG clock, so no PRNG sample is ever reused.
- Reseed latency from IDLE: Prng_Reset high in the next cycle, then Busy stays high for 1+WARMUP cycles.

## Test plan
- Reset release:
  - Stimulus: hold Reset_n low with Req=0, then release.
  - Required: Prng_Reset=1 and Prng_Seed=0x2A5 during reset and for 1 cycle after release. Busy=1 for 4 cycles, then 0. Ack=0 and Value=0 throughout.
- Rejection:
  - Stimulus: Req[0]=1, Max=5 (mask 7); bench drives Prng_Out=0x3FE, then 0x003.
  - Required: the first draw (m=6) is rejected. Ack=4'b0001 with Value=3 after the second draw edge.
- Fallback:
  - Stimulus: Req[2]=1, Max=4; Prng_Out held at 0x007.
  - Required: 7 rejections, then on the 8th draw Ack=4'b0100 with Value=2.
- Round-robin:
  - Stimulus: Req=4'b1111, all Max=1023, each requester drops Req after its Ack and re-raises it.
  - Required: grant order 0,1,2,3,0, with one Ack every 2 cycles and no overlap.
- Pending reseed:
  - Stimulus: Reseed=1 with Seed=0x000 while in DRAW; also Req[1]=1 on the IDLE edge.
  - Required: the in-flight Ack completes first. Then HOLD with Prng_Seed=0x2A5 (zero substituted). Busy holds for 4 cycles, and only after that is Req[1] granted.
- Asynchronous reset mid-DRAW:
  - Stimulus: pull Reset_n low during the rejection loop.
  - Required: Ack=0, Value=0, Busy=1 and Prng_Reset=1 immediately, with no clock edge needed. After release, no Ack is issued for the abandoned grant, and requester 0 wins first.
